sha256_round_engine: RTL and testbench
======================================

// Module: sha256_round_engine
// PURPOSE
//  Drives round_n into an external k_generator and consumes k_out as k_in; it is the initiator
//  side of that lookup. Accepts one pre-padded 512-bit block as 16 x 32-bit words over a
//  valid/ready stream. Runs the 64 SHA-256 compression rounds, one round per clock, and
//  returns the 256-bit digest. Sits between the padding/ingest front end and the result register.
// PARAMETERS
//  IV_SEL   0   initial hash: 0 = SHA-256 IV, 1 = SHA-224 IV (full 256-bit state still output)
// PORTS
//  clk           in   1    single clock, all logic rising-edge
//  rst_n         in   1    synchronous active-low reset
//  word_in       in   32   message word, W0 first, big-endian word order
//  word_valid    in   1    word_in valid
//  word_ready    out  1    engine accepts a word this cycle
//  round_n       out  6    round index to k_generator
//  k_in          in   32   K[round_n] from k_generator (combinational, same cycle)
//  busy          out  1    high in ROUND or FINAL
//  digest_out    out  256  H0 in [255:224] ... H7 in [31:0]
//  digest_valid  out  1    one-cycle pulse: digest_out updated
//  block_first   in   1    only with SHA256_CHAIN_EN; sampled with word 0
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE, word_cnt=0, round_n=0, busy=0, digest_valid=0,
//    digest_out=0, H regs=IV. Reset mid-LOAD/ROUND abandons the block; no digest is produced.
//  - States:
//    - IDLE: word_ready=1; first handshake -> LOAD (word_cnt=1).
//    - LOAD: word_ready=1; the 16th handshake -> ROUND with a..h <= H and round_n=0.
//    - ROUND: word_ready=0 (word_valid ignored); 64 cycles.
//    - FINAL: 1 cycle, H[i] <= H[i] + {a..h}[i] mod 2^32, then -> IDLE.
//  - Handshake: a word transfers on an edge where word_valid & word_ready; gaps are legal.
//    Words are shifted into a 16 x 32 schedule register w[0..15]; w[0] = oldest word.
//  - ROUND cycle t (round_n=t): W_t = w[0].
//    - T1 = h + S1(e) + Ch(e,f,g) + k_in + W_t; T2 = S0(a) + Maj(a,b,c).
//    - All adds mod 2^32; standard FIPS 180-4 rotates.
//    - Schedule shifts: w[i] <= w[i+1]; w[15] <= s1(w[14]) + w[9] + s0(w[1]) + w[0].
//    - round_n increments each ROUND cycle. round_n=63 -> FINAL (no wrap to 0 inside ROUND).
//    - round_n = 0 outside ROUND.
//  - Latency: 16th word accepted at edge E0. ROUND spans the 64 cycles after E0, then FINAL.
//    digest_out is updated at the FINAL edge, with digest_valid=1 in the cycle following it
//    (E0+65 edges). digest_valid is never high for 2 consecutive cycles.
//  - digest_out holds until the next FINAL or reset. A new block may begin loading in the
//    cycle digest_valid is high (IDLE, word_ready=1).
//  - Back-to-back: minimum block period = 16 load + 64 round + 1 final = 81 cycles.
// CONFIGURATION
//  SHA256_CHAIN_EN defined:
//    - block_first port exists.
//    - If block_first=1 on word 0, H is reloaded with IV at that handshake.
//    - Otherwise the previous H is used (multi-block messages).
//  SHA256_CHAIN_EN undefined:
//    - No block_first port.
//    - H is reset to IV on every word-0 handshake, so each block is an independent message.
// TESTING
//  - Bench instantiates k_generator and connects round_n and k_out to k_in.
//  - Block 61626380,0x0 x14,00000018 ("abc") -> digest_valid once, digest_out =
//    ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
//  - Block 80000000, then 15 x 00000000 (empty msg) ->
//    e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
//  - SHA256_CHAIN_EN: two padded blocks of "abcdbcdecdefdefg...nopq" (block_first=1, then 0)
//    -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, pulse only after
//    each block's FINAL.
//  - "abc" block with word_valid toggled 1/0 every cycle -> same digest; word_ready=0 for
//    exactly 65 cycles after the 16th word; digest_valid exactly E0+65.
//  - rst_n=0 for 1 cycle at round_n=30, then the "abc" block -> no pulse before reload;
//    after reload, digest = abc digest; round_n sequence observed 0..63 strictly increasing.

Source files
------------

// File: rtl/sha256_round_engine.sv
// rtl/sha256_round_engine.sv - SHA-256 compression engine, 16-word load then one round per clock
// Define SHA256_CHAIN_EN to add block_first and chain H across blocks of one message.
module sha256_round_engine #(
  parameter int IV_SEL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  word_in,
  input  logic         word_valid,
  output logic         word_ready,
  output logic [5:0]   round_n,
  input  logic [31:0]  k_in,
  output logic         busy,
  output logic [255:0] digest_out,
  output logic         digest_valid
`ifdef SHA256_CHAIN_EN
  ,
  input  logic         block_first
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FINAL
  } state_t;

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  word_cnt;
  logic [31:0] h_reg [8];
  logic [31:0] st [8];
  logic [31:0] w [16];
  logic [31:0] iv_w [8];
  logic [31:0] h_sum [8];
  logic [31:0] t1;
  logic [31:0] t2;
  logic [31:0] w_next;
  logic [255:0] digest_nxt;
  logic        xfer;
  logic        load_done;
  logic        reload_iv;

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

`ifdef SHA256_CHAIN_EN
  assign reload_iv = block_first;
`else
  assign reload_iv = 1'b1;
`endif

  assign xfer      = word_valid & word_ready;
  assign load_done = xfer && (state == S_LOAD) && (word_cnt == 4'd15);

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      iv_w[i]  = (IV_SEL != 0) ? IV224[i] : IV256[i];
      h_sum[i] = h_reg[i] + st[i];
    end
    digest_nxt = {h_sum[0], h_sum[1], h_sum[2], h_sum[3],
                  h_sum[4], h_sum[5], h_sum[6], h_sum[7]};
  end

  always_comb begin
    t1 = st[7] + big_s1(st[4]) + ((st[4] & st[5]) ^ (~st[4] & st[6])) + k_in + w[0];
    t2 = big_s0(st[0]) + ((st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]));
    w_next = small_s1(w[14]) + w[9] + small_s0(w[1]) + w[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    word_ready = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        word_ready = 1'b1;
        if (word_valid) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        word_ready = 1'b1;
        if (word_valid && word_cnt == 4'd15) state_nxt = S_ROUND;
      end
      S_ROUND: begin
        busy = 1'b1;
        if (round_n == 6'd63) state_nxt = S_FINAL;
      end
      S_FINAL: begin
        busy      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt     <= 4'd0;
      round_n      <= 6'd0;
      digest_valid <= 1'b0;
      digest_out   <= '0;
      for (int i = 0; i < 8; i++) h_reg[i] <= iv_w[i];
    end else begin
      digest_valid <= (state == S_FINAL);
      // word_cnt wraps 15 -> 0 on the last word, so IDLE always sees zero
      if (xfer) word_cnt <= word_cnt + 4'd1;
      if (xfer && state == S_IDLE && reload_iv) begin
        for (int i = 0; i < 8; i++) h_reg[i] <= iv_w[i];
      end
      if (state == S_ROUND && round_n != 6'd63) round_n <= round_n + 6'd1;
      else round_n <= 6'd0;
      if (state == S_FINAL) begin
        for (int i = 0; i < 8; i++) h_reg[i] <= h_sum[i];
        digest_out <= digest_nxt;
      end
    end
  end

  // Working state and schedule carry no reset: an abandoned block is simply reloaded.
  always_ff @(posedge clk) begin
    if (xfer || state == S_ROUND) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
      w[15] <= xfer ? word_in : w_next;
    end
    if (load_done) begin
      for (int i = 0; i < 8; i++) st[i] <= h_reg[i];
    end else if (state == S_ROUND) begin
      st[0] <= t1 + t2;
      st[1] <= st[0];
      st[2] <= st[1];
      st[3] <= st[2];
      st[4] <= st[3] + t1;
      st[5] <= st[4];
      st[6] <= st[5];
      st[7] <= st[6];
    end
  end

endmodule

// File: tb/tb_sha256_round_engine.sv
// tb/tb_sha256_round_engine.sv - directed vector bench for sha256_round_engine
// Supplies K[] as the external k_generator; chaining test runs when SHA256_CHAIN_EN is defined.
module tb_sha256_round_engine;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] DIG_ABC   =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic         clk;
  logic         rst_n;
  logic [31:0]  word_in;
  logic         word_valid;
  logic         word_ready;
  logic [5:0]   round_n;
  logic [31:0]  k_in;
  logic         busy;
  logic [255:0] digest_out;
  logic         digest_valid;
`ifdef SHA256_CHAIN_EN
  logic         block_first;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [511:0] blk;
    bit           toggle;
    logic [255:0] exp;
    string        name;
  } vec_t;

  vec_t vecs [3];

  assign k_in = K_TAB[round_n];

  sha256_round_engine #(.IV_SEL(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .round_n      (round_n),
    .k_in         (k_in),
    .busy         (busy),
    .digest_out   (digest_out),
    .digest_valid (digest_valid)
`ifdef SHA256_CHAIN_EN
    ,
    .block_first  (block_first)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_dig(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Leaves word_valid asserted for the cycle whose edge accepts word 15 (E0).
  task automatic load_block(input logic [511:0] blk, input bit toggle, input string nm);
    int i   = 0;
    int cyc = 0;
    bit ph  = 1'b0;
    while (i < 16 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      ph = toggle ? ~ph : 1'b1;
      word_valid = ph;
      word_in = ph ? blk[511 - 32*i -: 32] : 32'hbad0bad0;
      if (ph && word_ready) i++;
    end
    chk_int({nm, "_load_words"}, i, 16);
  endtask

  // Observation cycle j is the cycle after E0+j edges.
  task automatic observe(input logic [255:0] exp, input bit check_digest, input bit toggle,
                         input string nm);
    int first_dv = -1;
    int pulses   = 0;
    int rdy_low  = 0;
    int dbl      = 0;
    bit rnd_ok   = 1'b1;
    bit prev_dv  = 1'b0;
    bit ph       = 1'b0;
    logic [255:0] dig = '0;
    for (int j = 0; j < 70; j++) begin
      @(negedge clk);
      if (j < 65) begin
        ph = toggle ? ~ph : 1'b1;
        word_valid = ph;
        word_in = 32'hdead0000 | 32'(j);
      end else begin
        word_valid = 1'b0;
      end
      if (!word_ready) rdy_low++;
      if (j < 64 && (round_n !== 6'(j) || busy !== 1'b1)) rnd_ok = 1'b0;
      if (j == 64 && (round_n !== 6'd0 || busy !== 1'b1)) rnd_ok = 1'b0;
      if (j >= 65 && (round_n !== 6'd0 || busy !== 1'b0)) rnd_ok = 1'b0;
      if (digest_valid) begin
        pulses++;
        if (first_dv < 0) first_dv = j;
        if (prev_dv) dbl++;
        dig = digest_out;
      end
      prev_dv = digest_valid;
    end
    chk_int({nm, "_pulse_count"}, pulses, 1);
    chk_int({nm, "_pulse_cycle"}, first_dv, 65);
    chk_int({nm, "_double_pulse"}, dbl, 0);
    chk_int({nm, "_ready_low"}, rdy_low, 65);
    chk_int({nm, "_round_seq"}, int'(rnd_ok), 1);
    if (check_digest) begin
      chk_dig({nm, "_digest"}, dig, exp);
      chk_dig({nm, "_digest_hold"}, digest_out, exp);
    end
  endtask

  initial begin
    int cyc;
    int pulses;
    rst_n      = 1'b0;
    word_valid = 1'b0;
    word_in    = '0;
`ifdef SHA256_CHAIN_EN
    block_first = 1'b1;
`endif

    vecs[0].blk = BLK_ABC;   vecs[0].toggle = 1'b0; vecs[0].exp = DIG_ABC;   vecs[0].name = "abc";
    vecs[1].blk = BLK_EMPTY; vecs[1].toggle = 1'b0; vecs[1].exp = DIG_EMPTY; vecs[1].name = "empty";
    vecs[2].blk = BLK_ABC;   vecs[2].toggle = 1'b1; vecs[2].exp = DIG_ABC;   vecs[2].name = "abc_gaps";

    repeat (3) @(negedge clk);
    chk_int("rst_busy", int'(busy), 0);
    chk_int("rst_digest_valid", int'(digest_valid), 0);
    chk_int("rst_round_n", int'(round_n), 0);
    chk_int("rst_word_ready", int'(word_ready), 1);
    chk_dig("rst_digest_out", digest_out, '0);
    rst_n = 1'b1;

    for (int v = 0; v < 3; v++) begin
      load_block(vecs[v].blk, vecs[v].toggle, vecs[v].name);
      observe(vecs[v].exp, 1'b1, vecs[v].toggle, vecs[v].name);
    end

    // Reset in the middle of the rounds abandons the block.
    load_block(BLK_ABC, 1'b0, "abort");
    cyc = 0;
    do begin
      @(negedge clk);
      word_valid = 1'b0;
      cyc++;
    end while (round_n != 6'd30 && cyc < 100);
    chk_int("abort_reach_r30", int'(round_n), 30);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_int("abort_busy", int'(busy), 0);
    chk_int("abort_round_n", int'(round_n), 0);
    chk_int("abort_word_ready", int'(word_ready), 1);
    chk_dig("abort_digest_cleared", digest_out, '0);
    pulses = 0;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      if (digest_valid) pulses++;
    end
    chk_int("abort_no_pulse", pulses, 0);
    load_block(BLK_ABC, 1'b0, "reload");
    observe(DIG_ABC, 1'b1, 1'b0, "reload");

`ifdef SHA256_CHAIN_EN
    block_first = 1'b1;
    load_block({32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000}, 1'b0, "chain1");
    observe('0, 1'b0, 1'b0, "chain1");
    block_first = 1'b0;
    load_block({480'h0, 32'h000001c0}, 1'b0, "chain2");
    observe(256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1,
            1'b1, 1'b0, "chain2");
    block_first = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
